fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PROG_WORDS, default 6: number of valid instruction words; word indices 0..PROG_WORDS-1.
REQ-002 Parameter RESET_PC, default 0: first word index fetched after reset.
REQ-003 clock  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 readAddress  output  32: word index driven to instruction memory, equal to the internal PC.
REQ-006 instruction  input  32: word returned by instruction memory for readAddress, stable before the next rising edge.
REQ-007 redirect  input  1: branch or jump taken; valid for one cycle.
REQ-008 redirect_pc  input  32: target word index, qualified by redirect.
REQ-009 if_valid  output  1: IF/ID register holds an instruction.
REQ-010 if_ready  input  1: decode accepts the IF/ID contents this cycle.
REQ-011 if_instruction  output  32: latched instruction word.
REQ-012 if_pc  output  32: word index the latched instruction was fetched from.
REQ-013 done  output  1: fetch has stopped and the IF/ID register is empty.

Function
REQ-014 State machine states: IDLE, RUN, DRAIN; IDLE→RUN on the first edge after reset release, RUN→DRAIN when the PC leaves the range 0..PROG_WORDS-1, DRAIN is terminal until reset.
REQ-015 IDLE: PC = RESET_PC, no IF/ID load; gives instruction memory one cycle to settle.
REQ-016 Load condition: load = (state==RUN) && (!if_valid || if_ready).
REQ-017 On load: if_instruction <= instruction, if_pc <= PC, if_valid <= 1, PC <= PC+1 (32-bit, wraps modulo 2^32).
REQ-018 Stall: in RUN with if_valid && !if_ready, PC, if_instruction, if_pc and if_valid hold.
REQ-019 Accept without load: if_ready && if_valid && !load clears if_valid.
REQ-020 Redirect priority: redirect overrides load and stall; PC <= redirect_pc and if_valid <= 0 (flush), regardless of if_ready.
REQ-021 Redirect in DRAIN re-enters RUN when redirect_pc < PROG_WORDS; otherwise it is ignored.
REQ-022 Range check: any PC ≥ PROG_WORDS (after increment, redirect, or RESET_PC) forces RUN→DRAIN on that edge; no out-of-range word is ever loaded.
REQ-023 done = (state==DRAIN) && !if_valid, decoded combinationally from registered state.
REQ-024 Throughput: one instruction per cycle while if_ready stays high; latency readAddress→if_instruction is 1 edge.

Reset
REQ-025 Asserting reset at any time, including mid-stall or mid-redirect, immediately sets state=IDLE, PC=RESET_PC, if_valid=0, if_instruction=0, if_pc=0, done=0.
REQ-026 Release of reset takes effect on the next rising edge; no outputs change between reset assertion and that edge other than by REQ-025.

Configuration
REQ-027 Macro FETCH_TRACE_EN: when defined, each load prints one simulation line with the time, if_pc and the instruction in binary, and each redirect prints one line with the old and new PC; when undefined, no print statements exist and the behaviour is otherwise identical.

Verification
REQ-028 Reset, memory words 0..5 = distinct patterns, if_ready=1 → if_pc 0,1,2,3,4,5 on consecutive cycles with matching words; done=1 one cycle after if_pc=5 is accepted.
REQ-029 if_ready=0 for 3 cycles while if_pc=2 → if_pc, if_instruction and readAddress=3 hold; word 3 delivered on the first cycle after if_ready returns to 1.
REQ-030 redirect=1, redirect_pc=1 while if_pc=4 → if_valid=0 on the next cycle, then if_pc=1 the cycle after; word 4 is never accepted.
REQ-031 redirect with redirect_pc=9 (PROG_WORDS=6) → state DRAIN, if_valid=0, done=1; redirect to 0 from DRAIN resumes fetch at word 0.
REQ-032 redirect and if_valid && !if_ready in the same cycle → the flush wins and PC = redirect_pc.
REQ-033 reset asserted mid-stream at if_pc=3 → all outputs zero immediately, asynchronously; fetch restarts at RESET_PC after IDLE.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: sequential word fetcher feeding an IF/ID register with handshake.
// Ports: clock, reset(n), readAddress/instruction to imem, redirect/redirect_pc,
//   if_valid/if_ready/if_instruction/if_pc to decode, done. Trace: FETCH_TRACE_EN.
module fetch_unit #(
  parameter int unsigned PROG_WORDS = 6,
  parameter logic [31:0] RESET_PC   = '0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] readAddress,
  input  logic [31:0] instruction,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [31:0] LIMIT = 32'(PROG_WORDS);

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  logic [31:0] pc_inc;
  logic        valid_n;
  logic        load;
  logic        take;

  function automatic logic in_range(input logic [31:0] a);
    return a < LIMIT;
  endfunction

  assign pc_inc      = pc + 32'd1;
  assign readAddress = pc;
  assign load        = (state == RUN) && (!if_valid || if_ready);
  assign done        = (state == DRAIN) && !if_valid;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = if_valid;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        pc_n    = RESET_PC;
        state_n = in_range(RESET_PC) ? RUN : DRAIN;
      end
      RUN: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          valid_n = 1'b0;
          state_n = in_range(redirect_pc) ? RUN : DRAIN;
        end else if (load) begin
          take    = 1'b1;
          valid_n = 1'b1;
          pc_n    = pc_inc;
          if (!in_range(pc_inc))
            state_n = DRAIN;
        end else if (if_valid && if_ready) begin
          valid_n = 1'b0;
        end
      end
      DRAIN: begin
        // Only an in-range target may restart fetch.
        if (redirect && in_range(redirect_pc)) begin
          pc_n    = redirect_pc;
          valid_n = 1'b0;
          state_n = RUN;
        end else if (if_valid && if_ready) begin
          valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc             <= RESET_PC;
      if_valid       <= 1'b0;
      if_instruction <= '0;
      if_pc          <= '0;
    end else begin
      pc       <= pc_n;
      if_valid <= valid_n;
      if (take) begin
        if_instruction <= instruction;
        if_pc          <= pc;
      end
    end
  end

`ifdef FETCH_TRACE_EN
  logic redir_go;
  assign redir_go = redirect &&
    ((state == RUN) || ((state == DRAIN) && in_range(redirect_pc)));

  always @(posedge clock) begin
    if (reset && take)
      $display("%0t fetch pc=%0d instr=%b", $time, pc, instruction);
    if (reset && redir_go)
      $display("%0t redirect pc %0d -> %0d", $time, pc, redirect_pc);
  end
`endif

endmodule
